// File: rtl/ps2_rx.sv
// Purpose : PS/2 keyboard receiver; syncs and deglitches the pins, decodes 11-bit frames, emits scan-code bytes.
// Latency : pin edge to filtered edge SYNC_STAGES+FILTER_LEN cycles; valid rises 1 cycle after the filtered stop-bit fall.
// Backpr. : one-byte holding register; a good byte arriving while it is full and not being accepted is dropped (overflow).
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   ps2_clk, ps2_data  raw asynchronous PS/2 pins (idle high)
//   data, valid, ready received byte stream; data is stable while valid && !ready
//   parity_err         one-cycle pulse, frame dropped for bad (non-odd) parity
//   frame_err          one-cycle pulse, frame dropped for stop bit 0 or mid-frame timeout
//   overflow           one-cycle pulse, good byte dropped because the holding register was full
module ps2_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FLAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    // ---------------- synchronisers (index 0 = clk line, 1 = data line)
    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic [1:0]             sync_lvl;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign sync_lvl = {dat_sync_q[SYNC_STAGES-1], clk_sync_q[SYNC_STAGES-1]};

    // ---------------- stability filters
    // The counter tracks how many consecutive cycles the synced level has
    // disagreed with the filtered level; any agreement restarts it, so a
    // pulse shorter than FILTER_LEN never reaches the filtered output.
    logic [1:0]    filt_q, filt_d;
    logic [FW-1:0] fcnt_q [2];
    logic [FW-1:0] fcnt_d [2];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_d[i] = filt_q[i];
            fcnt_d[i] = '0;
            if (sync_lvl[i] != filt_q[i]) begin
                if (fcnt_q[i] == FLAST) begin
                    filt_d[i] = sync_lvl[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= 2'b11;
            for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < 2; i++) fcnt_q[i] <= fcnt_d[i];
        end
    end

    logic clk_prev_q;
    logic fall;
    logic dat_f;

    always_ff @(posedge clk) begin
        if (rst) clk_prev_q <= 1'b1;
        else     clk_prev_q <= filt_q[0];
    end

    assign fall  = clk_prev_q & ~filt_q[0];
    assign dat_f = filt_q[1];

    // ---------------- frame decoder and output register
    logic [1:0]    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          pe_q, pe_d;
    logic          fe_q, fe_d;
    logic          ov_q, ov_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        tmo_d     = tmo_q;
        data_d    = data_q;
        valid_d   = valid_q;
        pe_d      = 1'b0;
        fe_d      = 1'b0;
        ov_d      = 1'b0;

        if (valid_q && ready) valid_d = 1'b0;

        // Saturating inactivity counter, only meaningful mid-frame.
        if (state_q == S_IDLE || fall) tmo_d = '0;
        else if (tmo_q != TMAX)        tmo_d = tmo_q + 1'b1;

        if (fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!dat_f) begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                S_DATA: begin
                    shreg_d   = {dat_f, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = dat_f;
                    state_d = S_STOP;
                end
                default: begin
                    state_d = S_IDLE;
                    // Stop-bit failure takes precedence over parity failure.
                    if (!dat_f) begin
                        fe_d = 1'b1;
                    end else if (^{shreg_q, par_q} == 1'b0) begin
                        pe_d = 1'b1;
                    end else if (!valid_q || ready) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        ov_d = 1'b1;
                    end
                end
            endcase
        end else if (state_q != S_IDLE && tmo_q == TMAX) begin
            state_d = S_IDLE;
            fe_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            tmo_q     <= tmo_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            ov_q      <= ov_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = pe_q;
    assign frame_err  = fe_q;
    assign overflow   = ov_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Purpose : directed bench for ps2_rx with a byte scoreboard and error-pulse counters.
// Latency : PS/2 bit period 2*HALF cycles; shortened timeout keeps the run short.
// Backpr. : ready driven by the stimulus; bytes popped from the scoreboard on valid && ready.
module tb_ps2_rx;

    localparam int SYNC    = 2;
    localparam int FILT    = 8;
    localparam int TIMEOUT = 2000;
    localparam int HALF    = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    ps2_rx #(
        .SYNC_STAGES   (SYNC),
        .FILTER_LEN    (FILT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] exp_q[$];
    int pe_cnt = 0, fe_cnt = 0, ov_cnt = 0, wide_cnt = 0;
    logic pe_prev = 1'b0, fe_prev = 1'b0, ov_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer and error-pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid && ready) begin
                logic [7:0] e;
                e = 8'hxx;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                chk("rx_data", {24'd0, data}, {24'd0, e});
            end
            pe_cnt += int'(parity_err);
            fe_cnt += int'(frame_err);
            ov_cnt += int'(overflow);
            if ((parity_err && pe_prev) || (frame_err && fe_prev) || (overflow && ov_prev))
                wide_cnt++;
            pe_prev = parity_err;
            fe_prev = frame_err;
            ov_prev = overflow;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives bits[0..nbits-1] LSB first. In bit gbit the data line is flipped
    // for 3 cycles straddling the clock fall.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int gbit);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            if (i == gbit) begin
                cyc(HALF - 2);
                ps2_data = ~bits[i];
                cyc(2);
                ps2_clk = 1'b0;
                cyc(1);
                ps2_data = bits[i];
                cyc(HALF - 1);
            end else begin
                cyc(HALF);
                ps2_clk = 1'b0;
                cyc(HALF);
            end
            ps2_clk = 1'b1;
        end
        cyc(HALF);
        ps2_data = 1'b1;
        cyc(HALF);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop,
                              input int gbit);
        logic p;
        p = par_ok ? ~^b : ^b;
        send_bits({stop, p, b, 1'b0}, 11, gbit);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            cyc(1);
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        rst      = 1'b1;
        ready    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        cyc(3);
        chk("rst_data", {24'd0, data}, 0);
        chk("rst_valid", valid, 0);
        chk("rst_perr", parity_err, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        cyc(20);

        // 1: two good frames
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b1, 1'b1, -1);
        drain("t1_drain_1c");
        exp_q.push_back(8'hF0);
        send_frame(8'hF0, 1'b1, 1'b1, -1);
        drain("t1_drain_f0");
        cyc(5);
        chk("t1_valid_low", valid, 0);
        chk("t1_no_errs", pe_cnt + fe_cnt + ov_cnt, 0);

        // 2: parity error, then stop-bit error (parity good)
        send_frame(8'h1C, 1'b0, 1'b1, -1);
        cyc(20);
        chk("t2_perr_cnt", pe_cnt, 1);
        chk("t2_valid_pe", valid, 0);
        send_frame(8'h1C, 1'b1, 1'b0, -1);
        cyc(20);
        chk("t2_ferr_cnt", fe_cnt, 1);
        chk("t2_perr_same", pe_cnt, 1);
        chk("t2_valid_fe", valid, 0);

        // 3: stalled frame times out, next frame decodes
        send_bits({6'b111111, 5'b01010}, 5, -1);
        cyc(TIMEOUT + 10);
        chk("t3_timeout_ferr", fe_cnt, 2);
        exp_q.push_back(8'h2A);
        send_frame(8'h2A, 1'b1, 1'b1, -1);
        drain("t3_drain_2a");
        chk("t3_ferr_same", fe_cnt, 2);

        // 4: overflow while holding register full
        ready = 1'b0;
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b1, 1'b1, -1);
        send_frame(8'h32, 1'b1, 1'b1, -1);
        cyc(20);
        chk("t4_ovf_cnt", ov_cnt, 1);
        chk("t4_valid_held", valid, 1);
        chk("t4_data_held", {24'd0, data}, 32'h1C);
        ready = 1'b1;
        cyc(1);
        chk("t4_valid_drop", valid, 0);
        chk("t4_sb_empty", exp_q.size(), 0);
        exp_q.push_back(8'h45);
        send_frame(8'h45, 1'b1, 1'b1, -1);
        drain("t4_drain_45");

        // 5: short glitches are filtered out
        ps2_data = 1'b0;
        cyc(5);
        ps2_clk = 1'b0;
        cyc(3);
        ps2_clk = 1'b1;
        cyc(30);
        ps2_data = 1'b1;
        cyc(30);
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b1, 1'b1, 0);
        drain("t5_drain_glitch");
        chk("t5_err_totals", pe_cnt * 100 + fe_cnt * 10 + ov_cnt, 121);

        // 6: reset mid-frame with a byte held
        ready = 1'b0;
        send_frame(8'h1C, 1'b1, 1'b1, -1);
        cyc(10);
        chk("t6_valid_before", valid, 1);
        send_bits({7'b1111111, 4'b0110}, 4, -1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("t6_rst_valid", valid, 0);
        chk("t6_rst_data", {24'd0, data}, 0);
        chk("t6_rst_pulses", {parity_err, frame_err, overflow}, 0);
        ready = 1'b1;
        cyc(20);
        exp_q.push_back(8'h1C);
        send_frame(8'h1C, 1'b1, 1'b1, -1);
        drain("t6_drain_1c");

        cyc(20);
        chk("pulse_width", wide_cnt, 0);
        chk("final_err_totals", pe_cnt * 100 + fe_cnt * 10 + ov_cnt, 121);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
